// File: rtl/vga_timing_pattern_gen_if.sv
// rtl/vga_timing_pattern_gen_if.sv - raster/video output bundle of the VGA timing and pattern generator
interface vga_timing_pattern_gen_if #(
  parameter int RW = 3,
  parameter int GW = 3,
  parameter int BW = 2,
  parameter int CW = 11
);
  logic [RW-1:0] red;
  logic [GW-1:0] green;
  logic [BW-1:0] blue;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [CW-1:0] hpos;
  logic [CW-1:0] vpos;
  logic          pix_stb;
  logic          frame_start;

  modport master (
    output red, green, blue, hsync, vsync, de, hpos, vpos, pix_stb, frame_start
  );

  modport slave (
    input red, green, blue, hsync, vsync, de, hpos, vpos, pix_stb, frame_start
  );
endinterface

// File: rtl/vga_timing_pattern_gen.sv
// rtl/vga_timing_pattern_gen.sv - parametrised VGA raster timing and test-pattern generator
module vga_timing_pattern_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int RW       = 3,
  parameter int GW       = 3,
  parameter int BW       = 2,
  parameter int CW       = 11
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [1:0]            mode,
  input  logic [RW+GW+BW-1:0]   solid_rgb,
  vga_timing_pattern_gen_if.master vid
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0]         div_cnt;
  logic                  tick;
  logic [CW-1:0]         h;
  logic [CW-1:0]         v;
  logic                  h_last;
  logic                  v_last;
  logic                  at_origin;
  logic                  active;
  logic                  hs_on;
  logic                  vs_on;
  logic [1:0]            mode_q;
  logic [1:0]            eff_mode;
  logic [2:0]            bar;
  logic                  white;
  logic [RW+GW+BW-1:0]   rgb_nxt;

  assign tick      = (div_cnt == DIV_LAST);
  assign h_last    = (h == CW'(H_TOTAL - 1));
  assign v_last    = (v == CW'(V_TOTAL - 1));
  assign at_origin = (h == '0) && (v == '0);
  // pixel (0,0) already shows the newly selected mode; the rest of the frame uses the latched one
  assign eff_mode  = at_origin ? mode : mode_q;
  assign active    = (h < CW'(H_ACTIVE)) && (v < CW'(V_ACTIVE));
  assign hs_on     = (h >= CW'(H_ACTIVE + H_FP)) && (h < CW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_on     = (v >= CW'(V_ACTIVE + V_FP)) && (v < CW'(V_ACTIVE + V_FP + V_SYNC));

  // pixel-clock divider: tick fires once every CLK_DIV clocks
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // raster counters: h steps per tick, v steps on each line wrap
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h <= '0;
      v <= '0;
    end else if (tick) begin
      if (h_last) begin
        h <= '0;
        v <= v_last ? '0 : v + CW'(1);
      end else begin
        h <= h + CW'(1);
      end
    end
  end

  // mode latch: captured only when pixel (0,0) is registered
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= '0;
    end else if (tick && at_origin) begin
      mode_q <= mode;
    end
  end

  // bar index via comparator chain; remainder pixels fall through to bar 7 (black)
  always_comb begin
    bar = 3'd7;
    for (int i = 6; i >= 0; i--) begin
      if (h < CW'((i + 1) * BAR_W)) bar = 3'(i);
    end
  end

  // pattern colour for the current counter position
  always_comb begin
    rgb_nxt = '0;
    white   = 1'b0;
    case (eff_mode)
      2'd0:    rgb_nxt = {{RW{~bar[1]}}, {GW{~bar[2]}}, {BW{~bar[0]}}};
      2'd1:    white = ~(h[5] ^ v[5]);
      2'd2:    white = (h[4:0] == 5'd0) || (v[4:0] == 5'd0) ||
                       (h == CW'(H_ACTIVE - 1)) || (v == CW'(V_ACTIVE - 1));
      default: rgb_nxt = solid_rgb;
    endcase
    if (white) rgb_nxt = '1;
    if (!active) rgb_nxt = '0;
  end

  // output stage: every tick registers the pixel described by the pre-increment counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vid.red         <= '0;
      vid.green       <= '0;
      vid.blue        <= '0;
      vid.hsync       <= ~HS_POL;
      vid.vsync       <= ~VS_POL;
      vid.de          <= 1'b0;
      vid.hpos        <= '0;
      vid.vpos        <= '0;
      vid.pix_stb     <= 1'b0;
      vid.frame_start <= 1'b0;
    end else begin
      vid.pix_stb     <= tick;
      vid.frame_start <= tick && at_origin;
      if (tick) begin
        {vid.red, vid.green, vid.blue} <= rgb_nxt;
        vid.hsync <= hs_on ? HS_POL : ~HS_POL;
        vid.vsync <= vs_on ? VS_POL : ~VS_POL;
        vid.de    <= active;
        vid.hpos  <= h;
        vid.vpos  <= v;
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// tb/tb_vga_timing_pattern_gen.sv - self-checking bench for vga_timing_pattern_gen
module tb_vga_timing_pattern_gen;
  // index 0 = raster A (mid-size, CLK_DIV 3), 1 = raster B (small geometry), 2 = raster C (defaults)
  int g_div [3] = '{3, 1, 4};
  int g_ha  [3] = '{70, 20, 640};
  int g_hfp [3] = '{4, 2, 16};
  int g_hs  [3] = '{6, 3, 96};
  int g_hbp [3] = '{5, 3, 48};
  int g_va  [3] = '{40, 10, 480};
  int g_vfp [3] = '{2, 1, 10};
  int g_vs  [3] = '{3, 1, 2};
  int g_vbp [3] = '{2, 1, 33};
  bit g_hpol [3] = '{1'b0, 1'b1, 1'b0};
  bit g_vpol [3] = '{1'b1, 1'b0, 1'b0};
  logic [2:0] bar_tab [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode_in [3];
  logic [7:0]  solid [3];
  logic [34:0] act [3];

  int         e;
  logic [1:0] frame_mode [3];
  logic [7:0] cap_solid [3];
  int         n_checks = 0;
  int         n_errors = 0;

  vga_timing_pattern_gen_if vif_a ();
  vga_timing_pattern_gen_if vif_b ();
  vga_timing_pattern_gen_if vif_c ();

  vga_timing_pattern_gen #(
    .CLK_DIV(3), .H_ACTIVE(70), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_ACTIVE(40), .V_FP(2), .V_SYNC(3), .V_BP(2), .HS_POL(1'b0), .VS_POL(1'b1)
  ) dut_a (
    .clock(clk), .reset_n(rst_n), .mode(mode_in[0]), .solid_rgb(solid[0]), .vid(vif_a)
  );

  vga_timing_pattern_gen #(
    .CLK_DIV(1), .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(10), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b0)
  ) dut_b (
    .clock(clk), .reset_n(rst_n), .mode(mode_in[1]), .solid_rgb(solid[1]), .vid(vif_b)
  );

  vga_timing_pattern_gen dut_c (
    .clock(clk), .reset_n(rst_n), .mode(mode_in[2]), .solid_rgb(solid[2]), .vid(vif_c)
  );

  assign act[0] = {vif_a.red, vif_a.green, vif_a.blue, vif_a.hsync, vif_a.vsync, vif_a.de,
                   vif_a.hpos, vif_a.vpos, vif_a.pix_stb, vif_a.frame_start};
  assign act[1] = {vif_b.red, vif_b.green, vif_b.blue, vif_b.hsync, vif_b.vsync, vif_b.de,
                   vif_b.hpos, vif_b.vpos, vif_b.pix_stb, vif_b.frame_start};
  assign act[2] = {vif_c.red, vif_c.green, vif_c.blue, vif_c.hsync, vif_c.vsync, vif_c.de,
                   vif_c.hpos, vif_c.vpos, vif_c.pix_stb, vif_c.frame_start};

  always #5 clk = ~clk;

  function automatic int ht(input int i);
    return g_ha[i] + g_hfp[i] + g_hs[i] + g_hbp[i];
  endfunction

  function automatic int vt(input int i);
    return g_va[i] + g_vfp[i] + g_vs[i] + g_vbp[i];
  endfunction

  // expected outputs after e rising edges since reset release: pixel index = ticks - 1
  function automatic logic [34:0] model(input int i);
    int k, p, hh, vv, bar;
    logic [7:0] rgb;
    logic [2:0] c;
    logic hsv, vsv, dev, stb, fs, white;
    if (!rst_n || e < g_div[i]) return {8'h00, ~g_hpol[i], ~g_vpol[i], 25'd0};
    k   = e / g_div[i];
    p   = k - 1;
    hh  = p % ht(i);
    vv  = (p / ht(i)) % vt(i);
    dev = (hh < g_ha[i]) && (vv < g_va[i]);
    hsv = (hh >= g_ha[i] + g_hfp[i] && hh < g_ha[i] + g_hfp[i] + g_hs[i]) ? g_hpol[i] : ~g_hpol[i];
    vsv = (vv >= g_va[i] + g_vfp[i] && vv < g_va[i] + g_vfp[i] + g_vs[i]) ? g_vpol[i] : ~g_vpol[i];
    stb = (e % g_div[i]) == 0;
    fs  = stb && hh == 0 && vv == 0;
    rgb   = 8'h00;
    white = 1'b0;
    case (frame_mode[i])
      2'd0: begin
        bar = hh / (g_ha[i] / 8);
        if (bar < 8) begin
          c   = bar_tab[bar];
          rgb = {{3{c[2]}}, {3{c[1]}}, {2{c[0]}}};
        end
      end
      2'd1:    white = (((hh / 32) + (vv / 32)) % 2) == 0;
      2'd2:    white = (hh % 32 == 0) || (vv % 32 == 0) || (hh == g_ha[i] - 1) || (vv == g_va[i] - 1);
      default: rgb = cap_solid[i];
    endcase
    if (white) rgb = 8'hFF;
    if (!dev) rgb = 8'h00;
    return {rgb, hsv, vsv, dev, 11'(hh), 11'(vv), stb, fs};
  endfunction

  // model bookkeeping: edge count, per-tick solid sample, per-frame mode sample
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e <= 0;
      for (int i = 0; i < 3; i++) begin
        frame_mode[i] <= 2'd0;
        cap_solid[i]  <= 8'h00;
      end
    end else begin
      e <= e + 1;
      for (int i = 0; i < 3; i++) begin
        if ((e + 1) % g_div[i] == 0) begin
          cap_solid[i] <= solid[i];
          if ((((e + 1) / g_div[i]) - 1) % (ht(i) * vt(i)) == 0) frame_mode[i] <= mode_in[i];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [34:0] act_v, input logic [34:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act_v, exp_v);
    end
  endtask

  // compare every raster against the model on every falling edge
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) chk($sformatf("raster%0d@e%0d", i, e), act[i], model(i));
  end

  task automatic at_e(input int n);
    int guard;
    guard = 0;
    while (e < n && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
    chk($sformatf("reach_e%0d", n), 35'(e), 35'(n));
  endtask

  task automatic first_pixel_checks();
    at_e(3);
    chk("c_pre_hs", vif_c.hsync, 1'b1);
    chk("c_pre_vs", vif_c.vsync, 1'b1);
    chk("c_pre_de", vif_c.de, 1'b0);
    chk("c_pre_rgb", {vif_c.red, vif_c.green, vif_c.blue}, 8'h00);
    at_e(4);
    chk("c_first_pos", {vif_c.hpos, vif_c.vpos}, 22'd0);
    chk("c_first_de", vif_c.de, 1'b1);
    chk("c_first_rgb", {vif_c.red, vif_c.green, vif_c.blue}, 8'hFF);
    chk("c_first_fs", vif_c.frame_start, 1'b1);
    at_e(5);
    chk("c_fs_one_clock", vif_c.frame_start, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    mode_in[0] = 2'd0; mode_in[1] = 2'd2; mode_in[2] = 2'd0;
    for (int i = 0; i < 3; i++) solid[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("c_reset_hs", vif_c.hsync, 1'b1);
    chk("b_reset_hs", vif_b.hsync, 1'b0);
    rst_n = 1'b1;

    first_pixel_checks();
    at_e(22);  chk("b_hs_h21", vif_b.hsync, 1'b0);
    at_e(23);  chk("b_hs_h22", vif_b.hsync, 1'b1);
    at_e(25);  chk("b_hs_h24", vif_b.hsync, 1'b1);
    at_e(26);  chk("b_hs_h25", vif_b.hsync, 1'b0);
    at_e(34);  chk("b_grid_5_1", {vif_b.red, vif_b.green, vif_b.blue}, 8'h00);
    at_e(48);  chk("b_grid_19_1", {vif_b.red, vif_b.green, vif_b.blue}, 8'hFF);
    at_e(258); chk("b_grid_5_9", {vif_b.red, vif_b.green, vif_b.blue}, 8'hFF);
    at_e(281); chk("b_blank_de", vif_b.de, 1'b0);
    at_e(324); chk("c_bar_h80", {vif_c.hpos, vif_c.red, vif_c.green, vif_c.blue}, {11'd80, 8'hFC});
    at_e(365); chk("b_fs_frame1", vif_b.frame_start, 1'b1);
    at_e(728); chk("b_fs_gap", vif_b.frame_start, 1'b0);
    at_e(729); chk("b_fs_frame2", vif_b.frame_start, 1'b1);
    at_e(2560); chk("c_bar_h639", {vif_c.hpos, vif_c.de, vif_c.red, vif_c.green, vif_c.blue}, {11'd639, 1'b1, 8'h00});
    at_e(2564); chk("c_de_h640", vif_c.de, 1'b0);
    at_e(2624); chk("c_hs_h655", vif_c.hsync, 1'b1);
    at_e(2628); chk("c_hs_h656", {vif_c.hpos, vif_c.hsync}, {11'd656, 1'b0});
    at_e(3008); chk("c_hs_h751", vif_c.hsync, 1'b0);
    at_e(3012); chk("c_hs_h752", vif_c.hsync, 1'b1);
    at_e(3204); chk("c_line2", {vif_c.hpos, vif_c.vpos}, {11'd0, 11'd1});

    at_e(5103);
    mode_in[0] = 2'd3;
    solid[0]   = 8'hE0;
    at_e(6408);  chk("a_still_bars", {vif_a.hpos, vif_a.vpos, vif_a.red, vif_a.green, vif_a.blue}, {11'd10, 11'd25, 8'hFC});
    at_e(10458); chk("a_vs_v41", vif_a.vsync, 1'b0);
    at_e(10713); chk("a_vs_v42", vif_a.vsync, 1'b1);
    at_e(11988); chk("a_new_frame", {vif_a.frame_start, vif_a.red, vif_a.green, vif_a.blue}, {1'b1, 8'hE0});
    at_e(13293); chk("a_solid", {vif_a.red, vif_a.green, vif_a.blue}, 8'hE0);

    repeat (24000) begin
      @(negedge clk);
      solid[0] = 8'($urandom);
      solid[1] = 8'($urandom);
      if ($urandom_range(0, 399) == 0) mode_in[0] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) mode_in[1] = 2'($urandom_range(0, 3));
    end

    at_e(41079);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("a_async_reset", act[0], {8'h00, 1'b1, 1'b0, 25'd0});
    chk("b_async_reset", act[1], {8'h00, 1'b0, 1'b1, 25'd0});
    chk("c_async_reset", act[2], {8'h00, 1'b1, 1'b1, 25'd0});
    mode_in[0] = 2'd0;
    mode_in[1] = 2'd2;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    first_pixel_checks();
    at_e(48); chk("b_restart_grid", {vif_b.red, vif_b.green, vif_b.blue}, 8'hFF);
    repeat (2000) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/vga_timing_pattern_gen.md
# vga_timing_pattern_gen

Parametrised VGA timing and test-pattern generator for the MKR Vidor 4000 video path. It replaces the fixed 640x480 colour-bar generator. Horizontal and vertical timing, the pixel-clock divider, sync polarity and colour widths are all parameters, and it provides four pattern modes selected at run time. It also exports pixel coordinates, a data-enable and a frame strobe, so later blocks (framebuffer readers, overlays) can lock to the raster.

## Interface

Parameters:
- CLK_DIV, 4: system clocks per pixel; at least 1.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- HS_POL, 0: hsync active level.
- VS_POL, 0: vsync active level.
- RW, 3: red width. GW, 3: green width. BW, 2: blue width.
- CW, 11: coordinate counter width; must hold H_TOTAL-1 and V_TOTAL-1.

Ports:
- clock: in, 1. System clock; the only clock.
- reset_n: in, 1. Asynchronous, active-low reset.
- mode: in, 2. Pattern select: 0 = colour bars, 1 = checkerboard, 2 = grid, 3 = solid.
- solid_rgb: in, RW+GW+BW. Colour for mode 3, packed {r,g,b}.
- red: out, RW. Red output.
- green: out, GW. Green output.
- blue: out, BW. Blue output.
- hsync: out, 1. Horizontal sync.
- vsync: out, 1. Vertical sync.
- de: out, 1. High while the pixel is inside the active area.
- hpos: out, CW. Column of the pixel currently on the outputs.
- vpos: out, CW. Line of the pixel currently on the outputs.
- pix_stb: out, 1. One-clock pulse marking each clock where the outputs change.
- frame_start: out, 1. One-clock pulse marking when pixel (0,0) appears on the outputs.

## Operation

- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL is defined the same way. With defaults these are 800 and 525.
- **Divider:** an internal tick is high in one clock out of every CLK_DIV. With CLK_DIV=1 the tick is high every clock.
- **Counters:** h and v advance only on tick.
  - h counts 0 to H_TOTAL-1, then wraps to 0. v increments when h wraps.
  - v counts 0 to V_TOTAL-1, then wraps to 0.
- **Output stage:** on each tick, all outputs register from the pre-increment h/v values. Outputs hold between ticks.
- **Active area:** h < H_ACTIVE and v < V_ACTIVE. de=1 inside the active area, 0 outside. Outside the active area, red/green/blue = 0.
- **Sync:** hsync = HS_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL. vsync uses the same rule on v, with V_ACTIVE, V_FP, V_SYNC and VS_POL.
- **Mode latch:** mode is sampled into an internal register on the tick that registers pixel (0,0). A mode change mid-frame takes effect at the next frame.
- "Full" below means all ones on each channel.
- **Mode 0, colour bars:** BAR_W = H_ACTIVE/8, using integer division. Bars 0 to 7 are white, yellow, cyan, green, magenta, red, blue, black.
  - Yellow is r+g, cyan is g+b, magenta is r+b, each component at full.
  - Remainder pixels at the right edge are black.
  - The bar is chosen by a comparator chain; no hardware divider.
- **Mode 1, checkerboard:** white (full) when h[5]^v[5] = 0, black otherwise.
- **Mode 2, grid:** white when h[4:0]==0, v[4:0]==0, h==H_ACTIVE-1 or v==V_ACTIVE-1; black otherwise.
- **Mode 3, solid:** solid_rgb is sampled every tick.

## Timing

- **Reset values:**
  - Divider, h, v, hpos, vpos, red/green/blue and the mode register are all 0.
  - hsync = ~HS_POL and vsync = ~VS_POL.
  - de, pix_stb and frame_start are 0.
- **Reset behaviour:** assertion takes effect immediately, asynchronously, including mid-line or mid-frame. The raster restarts from (0,0) after release.
- **First tick:** on the CLK_DIV-th rising edge after reset_n deasserts. Later ticks follow every CLK_DIV edges.
- **Latency:** exactly one tick from the counter value to the outputs. hpos, vpos, de, syncs and colours always describe the same pixel.
- **pix_stb:** high for the clock following each tick edge.
- **frame_start:** high for the clock following the edge that registers (0,0). Period is H_TOTAL*V_TOTAL*CLK_DIV clocks.
- **Wrap:** on the tick with h=H_TOTAL-1 and v=V_TOTAL-1, both counters wrap to 0 together.

## Test plan

- **Reset to first pixel.** Defaults; release reset_n. Required response:
  - Before the 4th edge, hsync=vsync=1, de=0 and RGB=0.
  - After the 4th edge: hpos=0, vpos=0, de=1, red=111, green=111, blue=11, frame_start=1 for one clock.
- **Line timing.** Defaults. Required response:
  - hsync low for exactly 96 ticks (384 clocks), starting with hpos=656.
  - de high for 640 ticks per line.
  - Line period 3200 clocks.
- **Frame timing.** Defaults. Required response:
  - vsync low only while vpos is 490 or 491.
  - frame_start pulses are 1,680,000 clocks apart.
- **Bars and mid-frame mode change.** Mode 0. Required response:
  - hpos=80 gives r=111, g=111, b=00; hpos=639 gives 0.
  - Switching mode to 3 (solid_rgb=8'hE0) at vpos=100: output stays bars until the next frame_start, then red=111 and green=blue=0 everywhere active.
- **Small geometry.** Parameters CLK_DIV=1, H_ACTIVE=20, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=10, V_FP=1, V_SYNC=1, V_BP=1, HS_POL=1, mode 2. Required response:
  - hsync high for hpos 22 to 24.
  - Grid white at hpos 0 and 19, and at vpos 0 and 9.
  - frame_start every 364 clocks.
- **Asynchronous reset mid-frame.** Assert reset_n=0 at vpos=200 between edges. Required response:
  - All outputs take their reset values within the same cycle.
  - After release, the restart matches scenario 1.
